// File: rtl/instr_prefetch_queue_pkg.sv
// Shared widths and the queue entry payload for the instruction prefetch queue.
package instr_prefetch_queue_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [WIDTH-1:0] instr;
      logic [WIDTH-1:0] pc;
   } fetch_entry_t;

   localparam logic [WIDTH-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Memory-port, control and Decode-side signals of the prefetch queue.
interface instr_prefetch_queue_if;
   import instr_prefetch_queue_pkg::*;

   logic [WIDTH-1:0] mem_pc;
   logic [WIDTH-1:0] mem_instr;
   logic             fetch_stall;
   logic             redirect;
   logic [WIDTH-1:0] redirect_pc;
   logic             decode_ready;
   logic             instr_valid;
   logic [WIDTH-1:0] instr_out;
   logic [WIDTH-1:0] instr_pc;
   logic [WIDTH-1:0] pc_plus8;
   logic [CNT_W-1:0] count;

   modport master (
      input  mem_pc, instr_valid, instr_out, instr_pc, pc_plus8, count,
      output mem_instr, fetch_stall, redirect, redirect_pc, decode_ready
   );

   modport slave (
      output mem_pc, instr_valid, instr_out, instr_pc, pc_plus8, count,
      input  mem_instr, fetch_stall, redirect, redirect_pc, decode_ready
   );

endinterface

// File: rtl/instr_prefetch_queue_fifo.sv
// Circular buffer of fetched {instr, pc} entries with push, pop and flush.
module instr_prefetch_queue_fifo
   import instr_prefetch_queue_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  fetch_entry_t     i_data,
   output fetch_entry_t     o_head,
   output logic [CNT_W-1:0] o_count
);

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   fetch_entry_t     r_mem [DEPTH];

   // Flush drops all entries; it never coincides with push/pop at the top level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + PTR_W'(1);
         if (i_pop)  r_head <= r_head + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push && !i_flush) r_mem[r_tail] <= i_data;
   end

   assign o_head  = r_mem[r_head];
   assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch-side instruction buffer: owns the fetch PC, fills the queue one
// instruction per cycle and presents the head entry to Decode.
module instr_prefetch_queue
   import instr_prefetch_queue_pkg::*;
#(
   parameter int unsigned PCSTEP  = 4,
   parameter int unsigned RESETPC = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   instr_prefetch_queue_if.slave bus
);

   logic [WIDTH-1:0] r_fetch_pc;
   logic             w_valid;
   logic             w_pop;
   logic             w_push;
   logic [CNT_W-1:0] w_count;
   fetch_entry_t     w_head;
   fetch_entry_t     w_wr_data;

   assign w_valid   = (w_count != '0);
   assign w_pop     = w_valid && bus.decode_ready && !bus.redirect;
   assign w_push    = !bus.redirect && !bus.fetch_stall &&
                      ((w_count < CNT_W'(DEPTH)) || w_pop);
   assign w_wr_data = '{instr: bus.mem_instr, pc: r_fetch_pc};

   // Fetch PC advances only when the fetched word is actually captured.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fetch_pc <= WIDTH'(RESETPC);
      end else if (bus.redirect) begin
         r_fetch_pc <= bus.redirect_pc;
      end else if (w_push) begin
         r_fetch_pc <= r_fetch_pc + WIDTH'(PCSTEP);
      end
   end

   instr_prefetch_queue_fifo u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (bus.redirect),
      .i_data  (w_wr_data),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign bus.mem_pc      = r_fetch_pc;
   assign bus.count       = w_count;
   assign bus.instr_valid = w_valid;
   assign bus.instr_out   = w_valid ? w_head.instr : NOP_INSTR;
   assign bus.instr_pc    = w_valid ? w_head.pc : '0;
   assign bus.pc_plus8    = w_valid ? (w_head.pc + WIDTH'(8)) : '0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a queue-level reference model.
module tb_instr_prefetch_queue;
   import instr_prefetch_queue_pkg::*;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   instr_prefetch_queue_if bus();

   instr_prefetch_queue #(.PCSTEP(4), .RESETPC(0)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_instr = bus.mem_pc ^ 8'hA5;

   // Reference: a list of queued PCs plus the next PC to fetch.
   logic [7:0] mq[$];
   logic [7:0] m_fpc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_fpc = 8'h00;
      end else if (bus.redirect) begin
         mq.delete();
         m_fpc = bus.redirect_pc;
      end else begin
         automatic bit pop  = (mq.size() > 0) && bus.decode_ready;
         automatic bit push = !bus.fetch_stall && ((mq.size() < 4) || pop);
         if (pop) void'(mq.pop_front());
         if (push) begin
            mq.push_back(m_fpc);
            m_fpc = m_fpc + 8'd4;
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      automatic bit         v  = (mq.size() != 0);
      automatic logic [7:0] hp = v ? mq[0] : 8'h00;
      chk("model_valid", 8'(bus.instr_valid), 8'(v));
      chk("model_pc",    bus.instr_pc,  hp);
      chk("model_instr", bus.instr_out, v ? (hp ^ 8'hA5) : 8'h00);
      chk("model_p8",    bus.pc_plus8,  v ? (hp + 8'd8) : 8'h00);
      chk("model_count", 8'(bus.count), 8'(mq.size()));
      chk("model_mempc", bus.mem_pc,    m_fpc);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.redirect = 1'b0;
      bus.fetch_stall = 1'b0;
      tick(1);
      rst = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.fetch_stall = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = 8'h00;
      bus.decode_ready = 1'b1;
      tick(1);
      chk("rst_valid", 8'(bus.instr_valid), 8'h00);
      chk("rst_count", 8'(bus.count), 8'h00);
      chk("rst_mempc", bus.mem_pc, 8'h00);

      // 1: streaming with Decode always ready
      do_reset();
      tick(1);
      chk("t1_valid", 8'(bus.instr_valid), 8'h01);
      chk("t1_pc0",   bus.instr_pc,  8'h00);
      chk("t1_ins0",  bus.instr_out, 8'hA5);
      chk("t1_p8",    bus.pc_plus8,  8'h08);
      tick(1);
      chk("t1_pc1", bus.instr_pc, 8'h04);
      tick(1);
      chk("t1_pc2", bus.instr_pc, 8'h08);

      // 2: fill while Decode stalls, then one simultaneous pop+push
      bus.decode_ready = 1'b0;
      do_reset();
      tick(4);
      chk("t2_count", 8'(bus.count), 8'h04);
      chk("t2_mempc", bus.mem_pc,    8'h10);
      chk("t2_head",  bus.instr_pc,  8'h00);
      tick(1);
      chk("t2_hold",  bus.mem_pc,    8'h10);
      bus.decode_ready = 1'b1;
      tick(1);
      bus.decode_ready = 1'b0;
      chk("t2_pp_head",  bus.instr_pc,  8'h04);
      chk("t2_pp_count", 8'(bus.count), 8'h04);
      chk("t2_pp_mempc", bus.mem_pc,    8'h14);

      // 3: redirect with 3 entries queued
      do_reset();
      tick(3);
      chk("t3_count3", 8'(bus.count), 8'h03);
      bus.redirect = 1'b1;
      bus.redirect_pc = 8'h40;
      tick(1);
      bus.redirect = 1'b0;
      chk("t3_count0", 8'(bus.count), 8'h00);
      chk("t3_valid0", 8'(bus.instr_valid), 8'h00);
      chk("t3_mempc",  bus.mem_pc, 8'h40);
      tick(1);
      chk("t3_valid1", 8'(bus.instr_valid), 8'h01);
      chk("t3_pc",     bus.instr_pc,  8'h40);
      chk("t3_ins",    bus.instr_out, 8'hE5);

      // 4: fetch stall drains the queue without fetching
      do_reset();
      tick(2);
      chk("t4_count2", 8'(bus.count), 8'h02);
      bus.fetch_stall = 1'b1;
      bus.decode_ready = 1'b1;
      tick(1);
      chk("t4_drain1", bus.instr_pc, 8'h04);
      tick(1);
      chk("t4_empty", 8'(bus.instr_valid), 8'h00);
      tick(1);
      chk("t4_mempc", bus.mem_pc, 8'h08);
      bus.fetch_stall = 1'b0;
      tick(1);
      chk("t4_resume", bus.instr_pc, 8'h08);
      bus.decode_ready = 1'b0;

      // 5: fetch PC wraps past 0xFF
      bus.redirect = 1'b1;
      bus.redirect_pc = 8'hFC;
      tick(1);
      bus.redirect = 1'b0;
      tick(2);
      chk("t5_pc",    bus.instr_pc, 8'hFC);
      chk("t5_p8",    bus.pc_plus8, 8'h04);
      chk("t5_mempc", bus.mem_pc,   8'h04);
      bus.decode_ready = 1'b1;
      tick(1);
      bus.decode_ready = 1'b0;
      chk("t5_wrap",  bus.instr_pc,  8'h00);
      chk("t5_ins",   bus.instr_out, 8'hA5);

      // redirect together with stall: flush and load, fetch waits
      bus.redirect = 1'b1;
      bus.fetch_stall = 1'b1;
      bus.redirect_pc = 8'h80;
      tick(1);
      bus.redirect = 1'b0;
      tick(2);
      chk("rs_count", 8'(bus.count), 8'h00);
      chk("rs_mempc", bus.mem_pc, 8'h80);
      bus.fetch_stall = 1'b0;
      tick(1);
      chk("rs_pc", bus.instr_pc, 8'h80);

      // 6: asynchronous reset mid-cycle
      do_reset();
      tick(3);
      chk("t6_count3", 8'(bus.count), 8'h03);
      rst = 1'b1;
      #1;
      chk("t6_valid", 8'(bus.instr_valid), 8'h00);
      chk("t6_count", 8'(bus.count), 8'h00);
      chk("t6_ins",   bus.instr_out, 8'h00);
      chk("t6_mempc", bus.mem_pc, 8'h00);
      tick(1);
      rst = 1'b0;
      tick(1);
      chk("t6_restart", bus.instr_pc, 8'h00);
      chk("t6_rvalid",  8'(bus.instr_valid), 8'h01);

      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
